ineq_compare_sequencer: RTL and testbench

//  Bit-serial controller for the ALU inequality comparator: one 1-bit XOR

---
 rtl/alu_cmp_pkg.sv | 13 +
 rtl/ineq_bit_slice.sv | 11 +
 rtl/ineq_compare_sequencer.sv | 153 +++++++++++++++
 tb/tb_ineq_compare_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the bit-serial ALU inequality comparator:
// FSM state encoding and the default operand width.
package alu_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  localparam int CMP_WIDTH_DEFAULT = 5;

endpackage

// File: rtl/ineq_bit_slice.sv
// Single-bit inequality slice: reports whether one operand bit pair differs.
// Stepped across the operands by ineq_compare_sequencer.
module ineq_bit_slice (
  input  logic a_bit,
  input  logic b_bit,
  output logic diff_bit
);

  assign diff_bit = a_bit ^ b_bit;

endmodule

// File: rtl/ineq_compare_sequencer.sv
// Bit-serial inequality comparator controller: scans a/b LSB first through one
// XOR slice. Optional macro INEQ_CMP_EARLY_EXIT_EN stops the scan at the first mismatch.
import alu_cmp_pkg::*;

module ineq_compare_sequencer #(
  parameter  int WIDTH = CMP_WIDTH_DEFAULT,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff_mask,
  output logic             neq,
  output logic [IDXW-1:0]  first_diff
);

`ifdef INEQ_CMP_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

  cmp_state_e       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             neq_q, neq_d;
  logic [IDXW-1:0]  first_q, first_d;
  logic             start_ready_q, start_ready_d;
  logic             result_valid_q, result_valid_d;
  logic             diff_s;
  logic             first_hit_s;

  ineq_bit_slice u_slice (
    .a_bit    (a_q[idx_q]),
    .b_bit    (b_q[idx_q]),
    .diff_bit (diff_s)
  );

  assign first_hit_s = diff_s & ~neq_q;

  // Next-state, counter and result-register logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    neq_d   = neq_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          idx_d   = {IDXW{1'b0}};
          mask_d  = {WIDTH{1'b0}};
          neq_d   = 1'b0;
          first_d = {IDXW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = {IDXW{1'b0}};
          mask_d  = {WIDTH{1'b0}};
          neq_d   = 1'b0;
          first_d = {IDXW{1'b0}};
        end else begin
          mask_d[idx_q] = diff_s;
          if (first_hit_s) begin
            neq_d   = 1'b1;
            first_d = idx_q;
          end else begin
            neq_d   = neq_q;
          end
          // The counter parks on the last bit; it is reloaded on the next accept
          if ((idx_q == IDX_LAST) || (EARLY_EXIT && first_hit_s)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = {IDXW{1'b0}};
          mask_d  = {WIDTH{1'b0}};
          neq_d   = 1'b0;
          first_d = {IDXW{1'b0}};
        end else if (result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDXW{1'b0}};
        mask_d  = {WIDTH{1'b0}};
        neq_d   = 1'b0;
        first_d = {IDXW{1'b0}};
      end
    endcase
    start_ready_d  = (state_d == ST_IDLE);
    result_valid_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= {IDXW{1'b0}};
      a_q            <= {WIDTH{1'b0}};
      b_q            <= {WIDTH{1'b0}};
      mask_q         <= {WIDTH{1'b0}};
      neq_q          <= 1'b0;
      first_q        <= {IDXW{1'b0}};
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      a_q            <= a_d;
      b_q            <= b_d;
      mask_q         <= mask_d;
      neq_q          <= neq_d;
      first_q        <= first_d;
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign diff_mask    = mask_q;
  assign neq          = neq_q;
  assign first_diff   = first_q;

endmodule

// File: tb/tb_ineq_compare_sequencer.sv
// Directed self-checking bench for ineq_compare_sequencer (WIDTH=5).
// Expected values follow INEQ_CMP_EARLY_EXIT_EN when it is defined.
module tb_ineq_compare_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       abort;
  logic       result_valid;
  logic       result_ready;
  logic [4:0] diff_mask;
  logic       neq;
  logic [2:0] first_diff;

  int total = 0;
  int bad   = 0;

  ineq_compare_sequencer #(.WIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .abort        (abort),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .diff_mask    (diff_mask),
    .neq          (neq),
    .first_diff   (first_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for the result, check latency and fields (no consume)
  task automatic run_op(input string tag, input logic [4:0] av, input logic [4:0] bv,
                        input logic [4:0] em, input logic en, input logic [2:0] ef,
                        input int el);
    int n;
    @(negedge clk);
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start_valid = 1'b0;
    a = ~av;
    b = 5'b00000;
    n = 0;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(el));
    chk({tag, "_mask"}, 32'(diff_mask), 32'(em));
    chk({tag, "_neq"}, 32'(neq), 32'(en));
    chk({tag, "_first"}, 32'(first_diff), 32'(ef));
    chk({tag, "_busy"}, 32'(start_ready), 32'd0);
  endtask

  task automatic consume(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, "_rv_low"}, 32'(result_valid), 32'd0);
    chk({tag, "_idle"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    logic seen_rv;
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    a            = 5'b00000;
    b            = 5'b00000;
    abort        = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_mask", 32'(diff_mask), 32'd0);
    chk("rst_neq", 32'(neq), 32'd0);
    chk("rst_first", 32'(first_diff), 32'd0);
    rst_n = 1'b1;

`ifdef INEQ_CMP_EARLY_EXIT_EN
    run_op("v1", 5'b10101, 5'b01010, 5'b00001, 1'b1, 3'd0, 1);
    consume("v1");
    run_op("v2", 5'b00100, 5'b01011, 5'b00001, 1'b1, 3'd0, 1);
    consume("v2");
    run_op("v3", 5'b00011, 5'b01010, 5'b00001, 1'b1, 3'd0, 1);
    consume("v3");
    run_op("v4", 5'b00000, 5'b00000, 5'b00000, 1'b0, 3'd0, 5);
    consume("v4");
    run_op("v5", 5'b00100, 5'b00000, 5'b00100, 1'b1, 3'd2, 3);
`else
    run_op("v1", 5'b10101, 5'b01010, 5'b11111, 1'b1, 3'd0, 5);
    consume("v1");
    run_op("v2", 5'b00100, 5'b01011, 5'b01111, 1'b1, 3'd0, 5);
    consume("v2");
    run_op("v3", 5'b00011, 5'b01010, 5'b01001, 1'b1, 3'd0, 5);
    consume("v3");
    run_op("v4", 5'b00000, 5'b00000, 5'b00000, 1'b0, 3'd0, 5);
    consume("v4");
    run_op("v5", 5'b00100, 5'b00000, 5'b00100, 1'b1, 3'd2, 5);
`endif

    // Backpressure: hold the result while a new start is pending
    start_valid = 1'b1;
    a = 5'b10101;
    b = 5'b01010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rv", 32'(result_valid), 32'd1);
      chk("bp_mask", 32'(diff_mask), 32'h04);
      chk("bp_first", 32'(first_diff), 32'd2);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("bp_bubble_idle", 32'(start_ready), 32'd1);
    chk("bp_bubble_rv", 32'(result_valid), 32'd0);
    @(negedge clk);
    start_valid = 1'b0;
    chk("bp_accepted", 32'(start_ready), 32'd0);
    begin
      int n;
      n = 0;
      while (!result_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
`ifdef INEQ_CMP_EARLY_EXIT_EN
      chk("bp2_latency", 32'(n), 32'd1);
      chk("bp2_mask", 32'(diff_mask), 32'h01);
`else
      chk("bp2_latency", 32'(n), 32'd5);
      chk("bp2_mask", 32'(diff_mask), 32'h1f);
`endif
    end
    consume("bp2");

    // Abort in IDLE has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ready", 32'(start_ready), 32'd1);
    chk("idle_abort_rv", 32'(result_valid), 32'd0);

    // Abort on the second RUN edge
    start_valid = 1'b1;
    a = 5'b10101;
    b = 5'b01010;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 32'(start_ready), 32'd1);
    chk("abort_rv", 32'(result_valid), 32'd0);
    chk("abort_mask", 32'(diff_mask), 32'd0);
    chk("abort_neq", 32'(neq), 32'd0);
    chk("abort_first", 32'(first_diff), 32'd0);
    seen_rv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_rv = seen_rv | result_valid;
    end
    chk("abort_no_result", 32'(seen_rv), 32'd0);
`ifdef INEQ_CMP_EARLY_EXIT_EN
    run_op("post_abort", 5'b00011, 5'b01010, 5'b00001, 1'b1, 3'd0, 1);
`else
    run_op("post_abort", 5'b00011, 5'b01010, 5'b01001, 1'b1, 3'd0, 5);
`endif
    consume("post_abort");

    // Reset asserted between edges mid-RUN
    start_valid = 1'b1;
    a = 5'b00000;
    b = 5'b11111;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(start_ready), 32'd1);
    chk("midrst_rv", 32'(result_valid), 32'd0);
    chk("midrst_mask", 32'(diff_mask), 32'd0);
    chk("midrst_neq", 32'(neq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 5'b00000, 5'b00000, 5'b00000, 1'b0, 3'd0, 5);
    consume("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
